// File: rtl/ysyx_220053_lsu_pkg.sv
// Shared load/store unit definitions: MemOp encodings, FSM state encoding and the byte-mask helper.
package ysyx_220053_lsu_pkg;

  // MemOp[2] selects zero-extension; MemOp[1:0] is the access size.
  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_B  = 3'b001;
  localparam logic [2:0] OP_H  = 3'b010;
  localparam logic [2:0] OP_D  = 3'b011;
  localparam logic [2:0] OP_WU = 3'b100;
  localparam logic [2:0] OP_BU = 3'b101;
  localparam logic [2:0] OP_HU = 3'b110;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;
  localparam state_t S_RESP  = 2'd3;

  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b01:   size_mask = 8'h01;
      2'b10:   size_mask = 8'h03;
      2'b11:   size_mask = 8'hFF;
      default: size_mask = 8'h0F;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_220053_lsu_align.sv
// Combinational lane logic: store byte-enables and data shift, alignment/legality checks,
// and load-data extraction with sign or zero extension.
module ysyx_220053_lsu_align
  import ysyx_220053_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int NB = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [2:0]      op_i,
  input  logic            wen_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [NB-1:0]   wmask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misaligned_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] ldata_o
);

  logic [OFFW-1:0] off;
  logic [NB-1:0]   base_mask;
  logic [63:0]     rsh;
  logic [63:0]     ext;

  assign off       = addr_lo_i[OFFW-1:0];
  assign base_mask = NB'(size_mask(op_i[1:0]));
  assign wmask_o   = base_mask << off;
  assign wdata_o   = wdata_i << {off, 3'b000};
  assign rsh       = 64'(rdata_i >> {off, 3'b000});

  always_comb begin
    ext = rsh;
    case (op_i[1:0])
      2'b01:   ext = op_i[2] ? {56'd0, rsh[7:0]}  : {{56{rsh[7]}}, rsh[7:0]};
      2'b10:   ext = op_i[2] ? {48'd0, rsh[15:0]} : {{48{rsh[15]}}, rsh[15:0]};
      2'b00:   ext = op_i[2] ? {32'd0, rsh[31:0]} : {{32{rsh[31]}}, rsh[31:0]};
      default: ext = rsh;
    endcase
  end

  assign ldata_o = ext[XLEN-1:0];

  always_comb begin
    case (op_i[1:0])
      2'b10:   misaligned_o = addr_lo_i[0];
      2'b00:   misaligned_o = |addr_lo_i[1:0];
      2'b11:   misaligned_o = |addr_lo_i;
      default: misaligned_o = 1'b0;
    endcase
  end

  // Unsigned stores have no meaning; doubles do not exist on a 32-bit datapath.
  assign illegal_o = (op_i == 3'b111) || ((op_i[1:0] == 2'b11) && (XLEN == 32)) || (op_i[2] && wen_i);

endmodule

// File: rtl/ysyx_220053_lsu.sv
// Single-outstanding load/store unit between the core and an aligned-word memory port.
// Request accepted only when idle; every stage holds its outputs until the far side handshakes.
module ysyx_220053_lsu
  import ysyx_220053_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int AW = 64,
  localparam int NB = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [2:0]      req_op_i,
  input  logic            req_wen_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            mem_valid_o,
  input  logic            mem_ready_i,
  output logic [AW-1:0]   mem_addr_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [NB-1:0]   mem_wmask_o,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NB-1:0]   wmask_q, wmask_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            idle;
  logic [2:0]      al_op;
  logic            al_wen;
  logic [2:0]      al_lo;
  logic [NB-1:0]   al_wmask;
  logic [XLEN-1:0] al_wdata;
  logic [XLEN-1:0] al_ldata;
  logic            al_mis;
  logic            al_ill;

  // One align instance serves both phases: request checks while idle, load extraction later.
  assign idle   = (state_q == S_IDLE);
  assign al_op  = idle ? req_op_i : op_q;
  assign al_wen = idle ? req_wen_i : wen_q;
  assign al_lo  = idle ? req_addr_i[2:0] : addr_q[2:0];

  ysyx_220053_lsu_align #(.XLEN(XLEN)) u_align (
    .op_i         (al_op),
    .wen_i        (al_wen),
    .addr_lo_i    (al_lo),
    .wdata_i      (req_wdata_i),
    .rdata_i      (mem_rdata_i),
    .wmask_o      (al_wmask),
    .wdata_o      (al_wdata),
    .misaligned_o (al_mis),
    .illegal_o    (al_ill),
    .ldata_o      (al_ldata)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wen_d   = wen_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          wen_d   = req_wen_i;
          addr_d  = req_addr_i;
          wdata_d = al_wdata;
          wmask_d = req_wen_i ? al_wmask : '0;
          rdata_d = '0;
          err_d   = al_mis | al_ill;
          state_d = (al_mis | al_ill) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_ready_i) state_d = wen_q ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          rdata_d = al_ldata;
          state_d = S_RESP;
        end
      end
      default: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = idle;
  assign mem_valid_o = (state_q == S_ISSUE);
  assign mem_addr_o  = {addr_q[AW-1:OFFW], {OFFW{1'b0}}};
  assign mem_we_o    = mem_valid_o & wen_q;
  assign mem_wdata_o = wdata_q;
  assign mem_wmask_o = wmask_q;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_ysyx_220053_lsu.sv
// Directed bench for the load/store unit: a 64-bit instance for most scenarios and a 32-bit one for width-specific cases.
module tb_ysyx_220053_lsu;
  import ysyx_220053_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_op;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  logic        b_req_valid, b_req_ready, b_req_wen;
  logic [2:0]  b_req_op;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic        b_mem_valid, b_mem_ready, b_mem_we, b_mem_rvalid;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_wmask;

  int errors = 0;
  int checks = 0;
  int mem_valid_cycles = 0;

  always @(posedge clk) if (mem_valid === 1'b1) mem_valid_cycles++;

  ysyx_220053_lsu #(.XLEN(64), .AW(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op), .req_wen_i(req_wen),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
    .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  ysyx_220053_lsu #(.XLEN(32), .AW(32)) dut32 (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_op_i(b_req_op), .req_wen_i(b_req_wen),
    .req_addr_i(b_req_addr), .req_wdata_i(b_req_wdata),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err),
    .mem_valid_o(b_mem_valid), .mem_ready_i(b_mem_ready), .mem_addr_o(b_mem_addr), .mem_we_o(b_mem_we),
    .mem_wdata_o(b_mem_wdata), .mem_wmask_o(b_mem_wmask), .mem_rvalid_i(b_mem_rvalid), .mem_rdata_i(b_mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [2:0] op, input logic wen, input logic [63:0] addr, input logic [63:0] wdata);
    req_op = op; req_wen = wen; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until rsp_valid; 20 means the bound expired.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic b_accept(input logic [2:0] op, input logic [31:0] addr);
    b_req_op = op; b_req_wen = 1'b0; b_req_addr = addr; b_req_wdata = '0; b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0;
  endtask

  task automatic b_wait_rsp(output int lat);
    lat = 1;
    while (b_rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({req_ready, mem_valid, rsp_valid, rsp_err, mem_we} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=10000", {req_ready, mem_valid, rsp_valid, rsp_err, mem_we});
    end
    checks++;
    if ({mem_wmask, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      errors++; $display("FAIL reset_data wmask=%h addr=%h wdata=%h rdata=%h exp all 0", mem_wmask, mem_addr, mem_wdata, rsp_rdata);
    end
    checks++;
    if ({b_req_ready, b_mem_valid, b_rsp_valid, b_rsp_err, b_mem_wmask, b_mem_addr} !== {1'b1, 39'd0}) begin
      errors++; $display("FAIL reset_x32 ready=%b mvalid=%b rvalid=%b err=%b exp 1000", b_req_ready, b_mem_valid, b_rsp_valid, b_rsp_err);
    end
  endtask

  task automatic test_load_byte();
    int lat;
    mem_ready = 1'b1; mem_rvalid = 1'b1; rsp_ready = 1'b0;
    mem_rdata = 64'h0000_0000_80FF_0000;
    accept(OP_B, 1'b0, 64'h1003, 64'h0);
    checks++;
    if ({mem_valid, mem_we, mem_wmask, mem_addr} !== {1'b1, 1'b0, 8'h00, 64'h1000}) begin
      errors++; $display("FAIL lb_issue valid=%b we=%b wmask=%h addr=%h exp 1 0 00 1000", mem_valid, mem_we, mem_wmask, mem_addr);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 3) begin errors++; $display("FAIL lb_latency got=%0d exp=3", lat); end
    checks++;
    if ({rsp_err, rsp_rdata} !== {1'b0, 64'hFFFF_FFFF_FFFF_FF80}) begin
      errors++; $display("FAIL lb_data err=%b rdata=%h exp 0 ffffffffffffff80", rsp_err, rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_store_half();
    int lat;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    accept(OP_H, 1'b1, 64'h2006, 64'hBEEF);
    checks++;
    if ({mem_valid, mem_we, mem_wmask, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'hC0, 64'h2000, 64'hBEEF_0000_0000_0000}) begin
      errors++; $display("FAIL sh_issue valid=%b we=%b wmask=%h addr=%h wdata=%h", mem_valid, mem_we, mem_wmask, mem_addr, mem_wdata);
    end
    wait_rsp(lat);
    checks++;
    if (lat != 2 || {rsp_err, rsp_rdata} !== 65'd0) begin
      errors++; $display("FAIL sh_resp lat=%0d err=%b rdata=%h exp 2 0 0", lat, rsp_err, rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_back_to_back();
    int lat;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    accept(OP_B, 1'b1, 64'h6005, 64'hAB);
    checks++;
    if ({mem_we, mem_wmask, mem_wdata} !== {1'b1, 8'h20, 64'h0000_AB00_0000_0000}) begin
      errors++; $display("FAIL sb_issue we=%b wmask=%h wdata=%h exp 1 20 0000ab0000000000", mem_we, mem_wmask, mem_wdata);
    end
    wait_rsp(lat);
    finish_rsp();
    mem_rdata = 64'h0000_0000_8001_0000;
    accept(OP_H, 1'b0, 64'h7002, 64'h0);
    wait_rsp(lat);
    checks++;
    if (lat != 3 || rsp_rdata !== 64'hFFFF_FFFF_FFFF_8001) begin
      errors++; $display("FAIL lh_data lat=%0d rdata=%h exp 3 ffffffffffff8001", lat, rsp_rdata);
    end
    finish_rsp();
    mem_rdata = 64'hDEAD_BEEF_0123_4567;
    accept(OP_D, 1'b0, 64'h8000, 64'h0);
    wait_rsp(lat);
    checks++;
    if (lat != 3 || {rsp_err, rsp_rdata} !== {1'b0, 64'hDEAD_BEEF_0123_4567}) begin
      errors++; $display("FAIL ld_data lat=%0d err=%b rdata=%h exp 3 0 deadbeef01234567", lat, rsp_err, rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_errors();
    logic [2:0]  ops [5]   = '{OP_W, OP_BU, 3'b111, OP_D, OP_H};
    logic        wens [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] addrs [5] = '{64'h3002, 64'h10, 64'h20, 64'h8004, 64'h7001};
    int lat;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_valid_cycles = 0;
      accept(ops[i], wens[i], addrs[i], 64'h1234);
      wait_rsp(lat);
      checks++;
      if (lat != 1 || {rsp_err, rsp_rdata} !== {1'b1, 64'd0}) begin
        errors++; $display("FAIL err_case%0d lat=%0d err=%b rdata=%h exp 1 1 0", i, lat, rsp_err, rsp_rdata);
      end
      finish_rsp();
      checks++;
      if (mem_valid_cycles != 0) begin
        errors++; $display("FAIL err_memvalid%0d cycles=%0d exp 0", i, mem_valid_cycles);
      end
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int bad_rsp = 0;
    int hs = 0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; rsp_ready = 1'b0;
    mem_rdata = 64'h1234_5678_9ABC_DEF0;
    accept(OP_W, 1'b0, 64'h5008, 64'h55);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mem_ready = 1'b1;
      if (!(mem_valid === 1'b1 && mem_addr === 64'h5008 && mem_we === 1'b0 && mem_wmask === 8'h00 && mem_wdata === 64'h55)) bad++;
      tick();
    end
    mem_ready = 1'b0; mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_mem_hold bad_cycles=%0d exp 0", bad); end
    for (int i = 0; i < 3; i++) begin
      if (!(rsp_valid === 1'b1 && rsp_err === 1'b0 && rsp_rdata === 64'hFFFF_FFFF_9ABC_DEF0 && mem_valid === 1'b0)) bad_rsp++;
      tick();
    end
    checks++;
    if (bad_rsp != 0) begin errors++; $display("FAIL bp_rsp_hold bad_cycles=%0d exp 0 rdata=%h", bad_rsp, rsp_rdata); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid === 1'b1) hs++;
      tick();
    end
    rsp_ready = 1'b0;
    checks++;
    if (hs != 1 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_one_rsp handshakes=%0d ready=%b exp 1 1", hs, req_ready); end
  endtask

  task automatic test_reset_mid();
    int late = 0;
    mem_ready = 1'b1; mem_rvalid = 1'b0;
    accept(OP_D, 1'b1 ^ 1'b1, 64'h9000, 64'h0);
    tick();
    checks++;
    if ({req_ready, mem_valid, rsp_valid} !== 3'b000) begin
      errors++; $display("FAIL rm_in_wait got=%b exp=000", {req_ready, mem_valid, rsp_valid});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({req_ready, mem_valid, rsp_valid, rsp_err, mem_we} !== 5'b10000 || {mem_wmask, mem_addr, mem_wdata, rsp_rdata} !== '0) begin
      errors++; $display("FAIL rm_reset ctrl=%b addr=%h rdata=%h exp 10000 0 0", {req_ready, mem_valid, rsp_valid, rsp_err, mem_we}, mem_addr, rsp_rdata);
    end
    mem_rvalid = 1'b1; mem_rdata = 64'hFFFF_0000_FFFF_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || rsp_rdata !== 64'd0 || req_ready !== 1'b1) late++;
    end
    mem_rvalid = 1'b0;
    checks++;
    if (late != 0) begin errors++; $display("FAIL rm_late_rvalid bad_cycles=%0d exp 0", late); end
    rst = 1'b1; req_op = OP_W; req_wen = 1'b0; req_addr = 64'hA000; req_valid = 1'b1;
    tick();
    rst = 1'b0; req_valid = 1'b0;
    checks++;
    if ({req_ready, mem_valid, rsp_valid} !== 3'b100) begin
      errors++; $display("FAIL rm_priority got=%b exp=100", {req_ready, mem_valid, rsp_valid});
    end
  endtask

  task automatic test_unsigned_word();
    int lat;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    mem_rdata = 64'h8000_0001_DEAD_BEEF;
    accept(OP_WU, 1'b0, 64'h4004, 64'h0);
    checks++;
    if (mem_addr !== 64'h4000) begin errors++; $display("FAIL lwu_addr got=%h exp=4000", mem_addr); end
    wait_rsp(lat);
    checks++;
    if (lat != 3 || {rsp_err, rsp_rdata} !== {1'b0, 64'h0000_0000_8000_0001}) begin
      errors++; $display("FAIL lwu_data lat=%0d err=%b rdata=%h exp 3 0 0000000080000001", lat, rsp_err, rsp_rdata);
    end
    finish_rsp();
  endtask

  task automatic test_xlen32();
    int lat;
    b_mem_ready = 1'b1; b_mem_rvalid = 1'b1; b_mem_rdata = 32'h8000_0001;
    b_accept(OP_WU, 32'h4004);
    checks++;
    if ({b_mem_valid, b_mem_addr} !== {1'b1, 32'h4004}) begin
      errors++; $display("FAIL x32_lwu_issue valid=%b addr=%h exp 1 4004", b_mem_valid, b_mem_addr);
    end
    b_wait_rsp(lat);
    checks++;
    if (lat != 3 || {b_rsp_err, b_rsp_rdata} !== {1'b0, 32'h8000_0001}) begin
      errors++; $display("FAIL x32_lwu_data lat=%0d err=%b rdata=%h exp 3 0 80000001", lat, b_rsp_err, b_rsp_rdata);
    end
    b_rsp_ready = 1'b1; tick(); b_rsp_ready = 1'b0;
    b_accept(OP_B, 32'h4007);
    b_wait_rsp(lat);
    checks++;
    if (lat != 3 || b_rsp_rdata !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL x32_lb_data lat=%0d rdata=%h exp 3 ffffff80", lat, b_rsp_rdata);
    end
    b_rsp_ready = 1'b1; tick(); b_rsp_ready = 1'b0;
    b_accept(OP_D, 32'h4000);
    b_wait_rsp(lat);
    checks++;
    if (lat != 1 || {b_rsp_err, b_mem_valid, b_rsp_rdata} !== {1'b1, 1'b0, 32'd0}) begin
      errors++; $display("FAIL x32_double lat=%0d err=%b mvalid=%b rdata=%h exp 1 1 0 0", lat, b_rsp_err, b_mem_valid, b_rsp_rdata);
    end
    b_rsp_ready = 1'b1; tick(); b_rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    b_req_valid = 1'b0; b_req_op = '0; b_req_wen = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_rsp_ready = 1'b0; b_mem_ready = 1'b0; b_mem_rvalid = 1'b0; b_mem_rdata = '0;
    test_reset();
    test_load_byte();
    test_store_half();
    test_back_to_back();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_unsigned_word();
    test_xlen32();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_220053_lsu.md
YSYX_220053_LSU -- requirements
Module: ysyx_220053_LSU

Interface
REQ-001 Parameter XLEN, default 64, SHALL be the data width in bits; legal values are 32 and 64.
REQ-002 Parameter AW, default 64, SHALL be the address width in bits.
REQ-003 Derived constant NB = XLEN/8 SHALL be the byte-lane count; OFFW = log2(NB).
REQ-004 One clock, reset synchronous active-high. Ports: clk in 1 (system clock); rst in 1 (synchronous active-high reset).
REQ-005 Core request ports: req_valid in 1 (request present); req_ready out 1 (unit can accept); req_op in 3 (MemOp: [2]=zero-extend, [1:0] 00 word, 01 byte, 10 half, 11 double); req_wen in 1 (1=store); req_addr in AW (byte address); req_wdata in XLEN (store data, LSB-aligned).
REQ-006 Core response ports: rsp_valid out 1 (result ready); rsp_ready in 1 (core accepts); rsp_rdata out XLEN (extended load data, 0 for stores); rsp_err out 1 (misaligned or illegal op).
REQ-007 Memory-side ports: mem_valid out 1; mem_ready in 1; mem_addr out AW (NB-aligned); mem_we out 1; mem_wdata out XLEN (lane-shifted); mem_wmask out NB (byte enables); mem_rvalid in 1; mem_rdata in XLEN (full aligned word).

Function
REQ-008 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-009 IDLE: on req_valid, capture op, wen, addr, wdata; go to RESP with rsp_err=1 if the access is misaligned or illegal, otherwise go to ISSUE.
REQ-010 Misaligned: half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0. Illegal: op 111, or double when XLEN=32, or op[2]=1 with req_wen=1.
REQ-011 ISSUE: mem_valid=1 with stable mem_addr, mem_we, mem_wdata and mem_wmask until mem_ready=1; store then goes to RESP, load goes to WAIT.
REQ-012 WAIT: on mem_rvalid, register the extracted and extended data, then go to RESP.
REQ-013 RESP: rsp_valid=1 and outputs stable until rsp_ready=1, then return to IDLE; at most one transaction in flight.
REQ-014 Minimum latency, accept to rsp_valid, with mem_ready and mem_rvalid asserted immediately: load 3 cycles, store 2 cycles, error 1 cycle.
REQ-015 mem_addr SHALL be addr with low OFFW bits cleared.
REQ-016 mem_wmask SHALL be the size mask (byte 1, half 3, word F, double FF) shifted left by addr[OFFW-1:0], truncated to NB bits.
REQ-017 mem_wdata SHALL be req_wdata shifted left by 8*addr[OFFW-1:0].
REQ-018 Load extraction SHALL be mem_rdata shifted right by 8*offset, truncated to the access size; op[2]=0 sign-extends from the access MSB, op[2]=1 zero-extends; double is passed through unchanged.
REQ-019 mem_rvalid outside WAIT and mem_ready outside ISSUE SHALL be ignored.
REQ-020 rsp_rdata SHALL be 0 for stores and errored accesses.

Reset
REQ-021 rst SHALL force IDLE in the next cycle from any state, abandoning any in-flight access.
REQ-022 After reset: req_ready=1; mem_valid=0, rsp_valid=0, rsp_err=0; mem_we=0, mem_wmask=0; mem_addr, mem_wdata and rsp_rdata all 0.
REQ-023 rst SHALL take priority over every simultaneous handshake.

Structure
REQ-024 A shared package SHALL hold the MemOp encodings (OP_W, OP_B, OP_H, OP_D, OP_WU, OP_BU, OP_HU), the FSM state typedef, and the size-mask function.
REQ-025 One sub-module, ysyx_220053_LSU_align, SHALL be purely combinational and compute wmask, shifted wdata, misaligned/illegal flags and extended load data.
REQ-026 No behavioural memory-access calls SHALL appear inside the block.

Verification
REQ-027 Load byte, signed: addr=0x1003, mem_rdata=0x0000_0000_80FF_0000 -> rsp_rdata=0xFFFF_FFFF_FFFF_FF80, mem_addr=0x1000.
REQ-028 Store half: addr=0x2006, wdata=0xBEEF -> mem_wmask=0xC0, mem_wdata=0xBEEF_0000_0000_0000, mem_we=1.
REQ-029 Misaligned word: addr=0x3002 with MemOp word -> rsp_err=1 one cycle after accept, mem_valid never asserts.
REQ-030 Back-pressure: mem_ready low 5 cycles, then rsp_ready low 3 cycles -> mem and rsp outputs hold stable throughout and exactly one response is issued.
REQ-031 Reset mid-operation: rst asserted in WAIT -> next cycle in IDLE with all outputs at reset values, and a late mem_rvalid is ignored.
REQ-032 Unsigned word load: addr=0x4004, mem_rdata=0x8000_0001_xxxx_xxxx -> rsp_rdata=0x0000_0000_8000_0001; repeat with XLEN=32 and double op -> rsp_err=1.
